axis_stim_check: RTL and testbench
==================================

# axis_stim_check

Parametrised, synthesizable AXI-stream traffic generator and loopback checker. It drives a deterministic packet sequence into a stream DUT and checks the returned stream beat-by-beat. It reports pass/fail, packet counts and an error count. It is the next-generation in-fabric replacement for the fixed 64-bit stimulus models used in shell-level benches, generalised in width, packet count and length, and adding checking, timeout and optional backpressure.

## Interface
- DATA_WIDTH, 64, stream data width; multiple of 32, range 32..512; KEEP width is DATA_WIDTH/8 (BYTES).
- NUM_PKTS, 16, packets per run; range 1..65535.
- MAX_BEATS, 16, maximum packet length in beats; range 1..4096.
- TIMEOUT, 4096, cycles without a stream_in handshake before a run aborts; minimum 16.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a run from IDLE or DONE; ignored while running.
- aux_resetn  in  1  transmit enable (memory/shell ready); TX does not issue beats while low.
- stream_out_DATA / _KEEP / _LAST / _VALID  out  DATA_WIDTH / BYTES / 1 / 1  generated stream.
- stream_out_READY  in  1  downstream ready.
- stream_in_DATA / _KEEP / _LAST / _VALID  in  DATA_WIDTH / BYTES / 1 / 1  returned stream.
- stream_in_READY  out  1  checker ready.
- done  out  1  run finished; held until the next start or reset.
- pass  out  1  valid when done: 1 iff no errors and no timeout.
- timeout  out  1  run aborted by the watchdog.
- tx_pkt_count / rx_pkt_count  out  16 / 16  packets sent / received (a LAST beat handshaked).
- err_count  out  16  mismatching beats; saturates at 16'hFFFF.

## Operation
- Packet i (0-based) has length L_i = (i mod MAX_BEATS)+1 beats.
- For beat b of packet i, 32-bit lane j of DATA = {i[15:0], b[11:0], j[3:0]}.
- KEEP is all ones on every non-last beat. On the last beat it is {BYTES{1'b1}} >> (i mod BYTES).
- LAST is 1 only on beat L_i−1.
- TX FSM states: IDLE, SEND, FLUSH, DONE.
  - IDLE→SEND on start. Start clears all counters, done, pass and timeout.
  - SEND issues beats in order. After the LAST handshake of packet NUM_PKTS−1 it moves to FLUSH.
  - FLUSH waits for rx_pkt_count == NUM_PKTS or the watchdog. It then moves to DONE.
  - DONE→SEND on start.
- RX checker holds its own expected packet and beat counters, independent of TX.
- On every stream_in handshake, the checker compares KEEP and LAST exactly. It compares DATA only on bytes where the expected KEEP bit is 1.
- Any mismatch increments err_count by exactly 1 for that beat.
- A LAST beat, whether expected or not, resynchronises the checker: it advances to the next packet at beat 0.
- Beats received after NUM_PKTS packets each count as one error.
- The watchdog counts cycles in SEND/FLUSH with no stream_in handshake and clears on each handshake. When it reaches TIMEOUT, the block sets timeout=1, moves to DONE, sets done=1 and pass=0.
- If a timeout occurs while stream_out_VALID is high, VALID drops in the same cycle the FSM enters DONE. This is the only permitted VALID withdrawal.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and stream_in_READY is 0.
- First stream_out_VALID rises 1 cycle after start is sampled, provided aux_resetn=1.
- Back-to-back beats run at 1 beat/cycle while READY is held high. There are no idle cycles between packets.
- Outputs are registered. Once VALID is high, DATA/KEEP/LAST are stable until the handshake.
- If aux_resetn is low, no new beat is launched. A beat already presented stays valid until its handshake.
- stream_in_READY is 1 in SEND and FLUSH and 0 otherwise, unless the backpressure macro is defined.
- Counters update in the cycle after their handshake.
- done, pass and timeout assert together, 1 cycle after the final event.
- Asserting reset mid-run aborts immediately, with no drain.
- If a TX handshake and an RX handshake occur in the same cycle, both are processed independently.

## Configuration
- STIM_BACKPRESSURE_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1, reset to seed, steps every cycle) gates the handshakes:
  - stream_in_READY = running & (lfsr[0] | lfsr[1]).
  - TX only launches a new beat when lfsr[2]=1.
- STIM_BACKPRESSURE_EN undefined: READY is constantly 1 while running, and TX launches whenever allowed.

## Test plan
- Loopback out→in, DATA_WIDTH=64, NUM_PKTS=4, MAX_BEATS=4 → 10 beats total. Last-beat KEEP of packets 0..3 is FF, 7F, 3F, 1F. Result: done, pass=1, tx=rx=4, err=0.
- Loopback with byte 0 of beat 1, packet 2 flipped → err_count=1, pass=0, rx_pkt_count=4.
- Flip byte 7 of packet 1's last beat (KEEP=7F, byte masked) → err_count=0, pass=1.
- Hold aux_resetn=0 for 100 cycles after start → no VALID. Release → first VALID on the next cycle and the run passes.
- Sink stream_out_READY=0 with TIMEOUT=64 → timeout=1 and done=1 64 cycles after start. pass=0 and VALID drops.
- Assert reset mid-packet 2, then start again → all outputs 0 during reset. The rerun passes with identical data, and again passes with STIM_BACKPRESSURE_EN defined.

Source files
------------

// File: rtl/axis_stim_check.sv
// axis_stim_check: AXI-stream packet generator with a loopback checker, watchdog and result counters.
// Define STIM_BACKPRESSURE_EN to throttle both handshakes with a 16-bit LFSR.
module axis_stim_check #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_PKTS   = 16,
    parameter int MAX_BEATS  = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    aux_resetn,
    output logic [DATA_WIDTH-1:0]   stream_out_DATA,
    output logic [DATA_WIDTH/8-1:0] stream_out_KEEP,
    output logic                    stream_out_LAST,
    output logic                    stream_out_VALID,
    input  logic                    stream_out_READY,
    input  logic [DATA_WIDTH-1:0]   stream_in_DATA,
    input  logic [DATA_WIDTH/8-1:0] stream_in_KEEP,
    input  logic                    stream_in_LAST,
    input  logic                    stream_in_VALID,
    output logic                    stream_in_READY,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [15:0]             tx_pkt_count,
    output logic [15:0]             rx_pkt_count,
    output logic [15:0]             err_count
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LANES = DATA_WIDTH / 32;
    localparam int KW    = $clog2(BYTES);
    localparam int WW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND, FLUSH, DONE} state_t;

    state_t                  state_q, state_d;
    logic [15:0]             gen_pkt_q, gen_pkt_d, tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d, err_q, err_d;
    logic [11:0]             gen_beat_q, gen_beat_d, gen_lmod_q, gen_lmod_d;
    logic [11:0]             rx_beat_q, rx_beat_d, rx_lmod_q, rx_lmod_d;
    logic [KW-1:0]           gen_kmod_q, gen_kmod_d, rx_kmod_q, rx_kmod_d;
    logic                    vld_q, vld_d, last_q, last_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d, exp_data, byte_mask;
    logic [BYTES-1:0]        keep_q, keep_d, exp_keep;
    logic [WW-1:0]           wd_q, wd_d;
    logic                    done_q, done_d, pass_q, pass_d, tout_q, tout_d;
    logic                    running, rx_rdy, tx_ok, out_hs, in_hs, launch, gen_last, exp_last, mismatch, tx_final;

    function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [15:0] p, input logic [11:0] b);
        logic [DATA_WIDTH-1:0] d;
        d = '0;
        for (int j = 0; j < LANES; j++) d[32*j +: 32] = {p, b, 4'(j)};
        return d;
    endfunction

    function automatic logic [BYTES-1:0] beat_keep(input logic last, input logic [KW-1:0] k);
        return last ? {BYTES{1'b1}} >> k : {BYTES{1'b1}};
    endfunction

    assign running = (state_q == SEND) || (state_q == FLUSH);

`ifdef STIM_BACKPRESSURE_EN
    logic [15:0] lfsr_q, lfsr_d;
    always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end
    assign rx_rdy = running & (lfsr_q[0] | lfsr_q[1]);
    assign tx_ok  = lfsr_q[2];
`else
    assign rx_rdy = running;
    assign tx_ok  = 1'b1;
`endif

    assign out_hs   = vld_q & stream_out_READY;
    assign in_hs    = stream_in_VALID & rx_rdy;
    assign gen_last = gen_beat_q == gen_lmod_q;
    assign launch   = (state_q == SEND) && (!vld_q || out_hs) && aux_resetn && tx_ok && (gen_pkt_q < 16'(NUM_PKTS));
    assign tx_final = (state_q == SEND) && out_hs && last_q && (tx_cnt_q == 16'(NUM_PKTS - 1));

    // The checker's expected packet index is simply the number of LAST beats received so far.
    always_comb begin
        exp_last  = rx_beat_q == rx_lmod_q;
        exp_keep  = beat_keep(exp_last, rx_kmod_q);
        exp_data  = beat_data(rx_cnt_q, rx_beat_q);
        byte_mask = '0;
        for (int k = 0; k < BYTES; k++) byte_mask[8*k +: 8] = {8{exp_keep[k]}};
        mismatch  = (rx_cnt_q >= 16'(NUM_PKTS)) || (stream_in_KEEP != exp_keep) ||
                    (stream_in_LAST != exp_last) || (|((stream_in_DATA ^ exp_data) & byte_mask));
    end

    always_comb begin
        state_d    = state_q;
        gen_pkt_d  = gen_pkt_q;
        gen_beat_d = gen_beat_q;
        gen_lmod_d = gen_lmod_q;
        gen_kmod_d = gen_kmod_q;
        vld_d      = vld_q;
        data_d     = data_q;
        keep_d     = keep_q;
        last_d     = last_q;
        tx_cnt_d   = tx_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        rx_beat_d  = rx_beat_q;
        rx_lmod_d  = rx_lmod_q;
        rx_kmod_d  = rx_kmod_q;
        err_d      = err_q;
        wd_d       = wd_q;
        done_d     = done_q;
        pass_d     = pass_q;
        tout_d     = tout_q;
        if (out_hs) begin
            vld_d = 1'b0;
            if (last_q) tx_cnt_d = tx_cnt_q + 16'd1;
        end
        if (launch) begin
            vld_d  = 1'b1;
            data_d = beat_data(gen_pkt_q, gen_beat_q);
            keep_d = beat_keep(gen_last, gen_kmod_q);
            last_d = gen_last;
            if (gen_last) begin
                gen_pkt_d  = gen_pkt_q + 16'd1;
                gen_beat_d = '0;
                gen_lmod_d = (gen_lmod_q == 12'(MAX_BEATS - 1)) ? '0 : gen_lmod_q + 12'd1;
                gen_kmod_d = (gen_kmod_q == KW'(BYTES - 1)) ? '0 : gen_kmod_q + KW'(1);
            end else begin
                gen_beat_d = gen_beat_q + 12'd1;
            end
        end
        if (in_hs) begin
            wd_d = '0;
            if (mismatch && err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (stream_in_LAST) begin
                rx_cnt_d  = rx_cnt_q + 16'd1;
                rx_beat_d = '0;
                rx_lmod_d = (rx_lmod_q == 12'(MAX_BEATS - 1)) ? '0 : rx_lmod_q + 12'd1;
                rx_kmod_d = (rx_kmod_q == KW'(BYTES - 1)) ? '0 : rx_kmod_q + KW'(1);
            end else begin
                rx_beat_d = rx_beat_q + 12'd1;
            end
        end else if (running) begin
            wd_d = wd_q + WW'(1);
        end
        if (start && (state_q == IDLE || state_q == DONE)) begin
            state_d    = SEND;
            gen_pkt_d  = '0;
            gen_beat_d = '0;
            gen_lmod_d = '0;
            gen_kmod_d = '0;
            tx_cnt_d   = '0;
            rx_cnt_d   = '0;
            rx_beat_d  = '0;
            rx_lmod_d  = '0;
            rx_kmod_d  = '0;
            err_d      = '0;
            wd_d       = '0;
            done_d     = 1'b0;
            pass_d     = 1'b0;
            tout_d     = 1'b0;
        end else if (running && !in_hs && wd_q == WW'(TIMEOUT - 1)) begin
            state_d = DONE;
            vld_d   = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b0;
            tout_d  = 1'b1;
        end else if (rx_cnt_d >= 16'(NUM_PKTS) && (state_q == FLUSH || tx_final)) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = err_d == '0;
        end else if (tx_final) begin
            state_d = FLUSH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            gen_pkt_q  <= '0;
            gen_beat_q <= '0;
            gen_lmod_q <= '0;
            gen_kmod_q <= '0;
            vld_q      <= 1'b0;
            data_q     <= '0;
            keep_q     <= '0;
            last_q     <= 1'b0;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            rx_beat_q  <= '0;
            rx_lmod_q  <= '0;
            rx_kmod_q  <= '0;
            err_q      <= '0;
            wd_q       <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            tout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gen_pkt_q  <= gen_pkt_d;
            gen_beat_q <= gen_beat_d;
            gen_lmod_q <= gen_lmod_d;
            gen_kmod_q <= gen_kmod_d;
            vld_q      <= vld_d;
            data_q     <= data_d;
            keep_q     <= keep_d;
            last_q     <= last_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_beat_q  <= rx_beat_d;
            rx_lmod_q  <= rx_lmod_d;
            rx_kmod_q  <= rx_kmod_d;
            err_q      <= err_d;
            wd_q       <= wd_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            tout_q     <= tout_d;
        end
    end

    assign stream_out_DATA  = data_q;
    assign stream_out_KEEP  = keep_q;
    assign stream_out_LAST  = last_q;
    assign stream_out_VALID = vld_q;
    assign stream_in_READY  = rx_rdy;
    assign done             = done_q;
    assign pass             = pass_q;
    assign timeout          = tout_q;
    assign tx_pkt_count     = tx_cnt_q;
    assign rx_pkt_count     = rx_cnt_q;
    assign err_count        = err_q;
endmodule

// File: tb/tb_axis_stim_check.sv
// tb_axis_stim_check: loopback bench with byte-flip injection, random channel stalls and a packet-level reference model.
module tb_axis_stim_check;
    localparam int DW = 64, NP = 4, MB = 4, TO = 128, NB = DW / 8;

    logic          clk = 1'b0, reset = 1'b0, start = 1'b0, aux_resetn = 1'b1, gate = 1'b1;
    logic [DW-1:0] out_data, in_data, flip_mask;
    logic [NB-1:0] out_keep, in_keep;
    logic          out_last, out_valid, out_ready, in_last, in_valid, in_ready;
    logic          done, pass, timeout;
    logic [15:0]   tx_cnt, rx_cnt, err_cnt;

    int n_tests = 0, n_fail = 0;
    int fp[4], fb[4], fy[4];
    int nflip = 0;
    int exp_pkt = 0, exp_beat = 0, nbeats = 0;
    logic fin = 1'b0;

    always #5 clk = ~clk;

    axis_stim_check #(.DATA_WIDTH(DW), .NUM_PKTS(NP), .MAX_BEATS(MB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .aux_resetn(aux_resetn),
        .stream_out_DATA(out_data), .stream_out_KEEP(out_keep), .stream_out_LAST(out_last),
        .stream_out_VALID(out_valid), .stream_out_READY(out_ready),
        .stream_in_DATA(in_data), .stream_in_KEEP(in_keep), .stream_in_LAST(in_last),
        .stream_in_VALID(in_valid), .stream_in_READY(in_ready),
        .done(done), .pass(pass), .timeout(timeout),
        .tx_pkt_count(tx_cnt), .rx_pkt_count(rx_cnt), .err_count(err_cnt)
    );

    // Loopback channel: the beat identity is read from lane 0 so flips land on the intended beat.
    always_comb begin
        flip_mask = '0;
        for (int i = 0; i < 4; i++)
            if (i < nflip && int'(out_data[31:16]) == fp[i] && int'(out_data[15:4]) == fb[i])
                flip_mask[8*fy[i] +: 8] = 8'hFF;
    end
    assign in_data   = out_data ^ flip_mask;
    assign in_keep   = out_keep;
    assign in_last   = out_last;
    assign in_valid  = out_valid & gate;
    assign out_ready = in_ready & gate;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_len(input int p);
        return p % MB + 1;
    endfunction

    function automatic logic [63:0] m_data(input int p, input int b);
        logic [63:0] d;
        for (int j = 0; j < 2; j++) d[32*j +: 32] = 32'((p % 65536) * 65536 + (b % 4096) * 16 + j);
        return d;
    endfunction

    function automatic logic [7:0] m_keep(input int p, input int b);
        return (b == m_len(p) - 1) ? 8'hFF >> (p % NB) : 8'hFF;
    endfunction

    function automatic int m_total();
        int t = 0;
        for (int p = 0; p < NP; p++) t += m_len(p);
        return t;
    endfunction

    function automatic int m_errs();
        int e = 0;
        for (int p = 0; p < NP; p++)
            for (int b = 0; b < m_len(p); b++) begin
                logic [7:0] k = m_keep(p, b);
                bit bad = 0;
                for (int i = 0; i < nflip; i++)
                    if (fp[i] == p && fb[i] == b && k[fy[i]]) bad = 1;
                e += int'(bad);
            end
        return e;
    endfunction

    // Generator monitor: every transmitted beat is compared with the model.
    always @(negedge clk) begin
        if (reset || start) begin
            exp_pkt = 0; exp_beat = 0; nbeats = 0; fin = 1'b0;
        end else begin
            if (fin) begin
                check("done_lat", done, 1);
                fin = 1'b0;
            end
            if (out_valid && out_ready) begin
                check("tx_data", out_data, m_data(exp_pkt, exp_beat));
                check("tx_keep", out_keep, m_keep(exp_pkt, exp_beat));
                check("tx_last", out_last, exp_beat == m_len(exp_pkt) - 1);
                nbeats++;
                if (exp_beat == m_len(exp_pkt) - 1) begin
                    if (exp_pkt == NP - 1) begin
                        check("done_early", done, 0);
                        fin = 1'b1;
                    end
                    exp_pkt++;
                    exp_beat = 0;
                end else begin
                    exp_beat++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        int c = 0;
        while (!done && c < 3000) begin
            if (rnd) begin
                gate = $urandom_range(0, 3) != 0;
                aux_resetn = $urandom_range(0, 7) != 0;
            end
            step();
            c++;
        end
        gate = 1'b1;
        aux_resetn = 1'b1;
        check("wait_done", done, 1);
    endtask

    task automatic results(input string tag);
        int e = m_errs();
        check({tag, "_pass"}, pass, e == 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_err"}, err_cnt, 64'(e));
        check({tag, "_tx"}, tx_cnt, NP);
        check({tag, "_rx"}, rx_cnt, NP);
        check({tag, "_beats"}, nbeats, 64'(m_total()));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_keep"}, out_keep, 0);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_flags"}, {done, pass, timeout}, 0);
        check({tag, "_cnts"}, {tx_cnt, rx_cnt, err_cnt}, 0);
    endtask

    initial begin
        bit seen;
        int c;
        #1 reset = 1'b1;
        repeat (3) step();
        check_idle_outputs("rst");
        reset = 1'b0;
        step();

        nflip = 0;
        pulse_start();
        check("start_valid0", out_valid, 0);
`ifndef STIM_BACKPRESSURE_EN
        step();
        check("first_valid", out_valid, 1);
`endif
        wait_done(0);
        results("clean");

        nflip = 1; fp[0] = 2; fb[0] = 1; fy[0] = 0;
        pulse_start();
        wait_done(0);
        results("flip_b0");
        check("flip_b0_err1", err_cnt, 1);

        nflip = 1; fp[0] = 1; fb[0] = 1; fy[0] = 7;
        pulse_start();
        wait_done(0);
        results("flip_masked");

        nflip = 0;
        aux_resetn = 1'b0;
        pulse_start();
        seen = 0;
        repeat (100) begin
            step();
            seen |= out_valid;
        end
        check("aux_hold", seen, 0);
        aux_resetn = 1'b1;
`ifndef STIM_BACKPRESSURE_EN
        step();
        check("aux_valid", out_valid, 1);
`endif
        wait_done(0);
        results("aux");

        for (int r = 0; r < 6; r++) begin
            nflip = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) begin
                fp[i] = $urandom_range(0, NP - 1);
                fb[i] = $urandom_range(0, m_len(fp[i]) - 1);
                fy[i] = $urandom_range(0, NB - 1);
            end
            pulse_start();
            wait_done(1);
            results("rand");
        end

        nflip = 0;
        gate = 1'b0;
        pulse_start();
        repeat (TO - 1) step();
        check("to_done_early", done, 0);
        check("to_valid_before", out_valid, 1);
        step();
        check("to_done", done, 1);
        check("to_flag", timeout, 1);
        check("to_pass", pass, 0);
        check("to_valid_drop", out_valid, 0);
        gate = 1'b1;

        pulse_start();
        c = 0;
        while (!(exp_pkt == 2 && exp_beat == 1) && c < 200) begin
            step();
            c++;
        end
        check("reach_pkt2", exp_pkt == 2 && exp_beat == 1, 1);
        reset = 1'b1;
        #2;
        check_idle_outputs("midrst");
        step();
        step();
        check_idle_outputs("midrst_hold");
        reset = 1'b0;
        step();
        pulse_start();
        wait_done(0);
        results("rerun");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
